countdown_hhmm_mux: RTL and testbench
=====================================

COUNTDOWN_HHMM_MUX -- requirements
Module: countdown_hhmm_mux

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5_000_000: clk0 cycles per count step (>=2).
REQ-002 SHALL have parameter SCAN_DIV, default 1024: clk0 cycles per display digit slot (power of two, >=4).
REQ-003 SHALL have parameter HOUR_MOD, default 24: hour modulus (legal 12 or 24).
REQ-004 SHALL have parameter AUTO_RELOAD, default 1: 1 = wrap at 00:00, 0 = stop at 00:00.
REQ-005 SHALL have port clk0  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port run  in  1  level; 1 = counting enabled, 0 = paused.
REQ-008 SHALL have port load  in  1  single-cycle pulse; loads preset.
REQ-009 SHALL have port preset  in  16  BCD {H10,H1,M10,M1}.
REQ-010 SHALL have port count_bcd  out  16  current BCD value {H10,H1,M10,M1}.
REQ-011 SHALL have port seg7  out  8  {dp=0, segments g..a}, active-high.
REQ-012 SHALL have port line  out  4  one-hot digit select; bit0 = H10, bit3 = M1.
REQ-013 SHALL have port done  out  1  level; 1 while value is 00:00 and the counter is stopped (AUTO_RELOAD=0 only).
REQ-014 SHALL have port load_err  out  1  one-cycle pulse on a rejected load.

Function
REQ-015 SHALL use a free-running prescaler 0..TICK_DIV-1; tick = one-cycle pulse at terminal count; the prescaler runs regardless of run.
REQ-016 SHALL decrement count_bcd by one minute on tick when run=1 and done=0; the new value is visible the cycle after the tick.
REQ-017 SHALL borrow M1 9<-0 into M10, M10 5<-0 into hours, H1 9<-0 into H10; hours count down HOUR_MOD-1..0.
REQ-018 SHALL, at 00:00 with tick, load {HOUR_MOD-1}:59 when AUTO_RELOAD=1 (e.g. 23:59), and set done while holding 00:00 when AUTO_RELOAD=0.
REQ-019 SHALL accept a load only if every digit <=9, M10 <=5 and hours <HOUR_MOD; a valid load updates count_bcd the next cycle and clears done.
REQ-020 SHALL ignore an invalid load (count_bcd unchanged) and pulse load_err for one cycle.
REQ-021 SHALL give load priority over a tick in the same cycle; that tick is discarded.
REQ-022 SHALL, when loaded with 00:00 and AUTO_RELOAD=0, assert done on the next tick with run=1.
REQ-023 SHALL have the scan counter advance the digit slot every SCAN_DIV cycles in the order H10,H1,M10,M1, wrapping to H10.
REQ-024 SHALL update line and seg7 together in the same cycle; seg7 always shows the digit selected by line, with no one-slot lag.
REQ-025 SHALL hold seg7 segments at 0 (blank) when a decoded digit is >9.

Reset
REQ-026 SHALL, while rst_n=0, force count_bcd=16'h0000, done=0, load_err=0, prescaler=0, scan slot=H10, line=4'b0001, seg7=8'h3F.
REQ-027 SHALL abandon any pending tick or load when reset is asserted mid-operation; counting resumes from 00:00 once rst_n is released.

Configuration
REQ-028 SHALL, when macro COUNTDOWN_HHMM_BLINK_EN is defined, blank seg7 (line keeps scanning) during alternate half-periods of a ~1 Hz blink derived from tick while done=1.
REQ-029 SHALL, when COUNTDOWN_HHMM_BLINK_EN is undefined, include no blink logic; seg7 shows 00:00 steadily while done=1.

Structure
REQ-030 SHALL place the seg7 digit-pattern constant table (0..9) and the BCD digit typedef in shared package seg7_pkg.
REQ-031 SHALL implement the decode as sub-module seg7_decode (4-bit in, 7-bit out, blank for >9), instantiated once.

Verification (bench with TICK_DIV=4, SCAN_DIV=4)
REQ-032 SHALL verify wrap: load 00:01, run=1 -> after 1 tick 00:00, after 2 ticks 23:59 (HOUR_MOD=24) or 11:59 (HOUR_MOD=12); done stays 0.
REQ-033 SHALL verify stop: AUTO_RELOAD=0, load 00:02, run=1 -> 00:01, then 00:00 with done=1 on that tick's cycle+1; further ticks hold 00:00.
REQ-034 SHALL verify load rejection: load 16'h2400 with HOUR_MOD=24, or 16'h0160 -> load_err one cycle, count_bcd unchanged.
REQ-035 SHALL verify load vs tick: load 12:34 on the tick cycle -> count_bcd=12:34; the next tick gives 12:33.
REQ-036 SHALL verify scan: with value 19:05, line steps 0001,0010,0100,1000 every 4 cycles; seg7 = 06,6F,3F,6D (hex) respectively.
REQ-037 SHALL verify reset: assert rst_n=0 asynchronously mid-count -> all outputs at their REQ-026 values without waiting for a clock edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: BCD digit type and the 0..9 segment patterns
// (active-high, bit order g..a).
package seg7_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    localparam logic [6:0] SEG7_TABLE [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to seven-segment pattern; codes above 9 produce a blank (all off).
module seg7_decode
    import seg7_pkg::*;
(
    input  bcd_digit_t digit,
    output logic [6:0] seg
);

    // Table lookup for decimal codes, blank for anything else.
    always_comb begin
        seg = 7'h00;
        if (digit <= BCD_MAX) begin
            seg = SEG7_TABLE[digit];
        end else begin
            seg = 7'h00;
        end
    end

endmodule

// File: rtl/countdown_hhmm_mux.sv
// HH:MM countdown timer with a multiplexed four-digit seven-segment display.
// Optional feature macro: COUNTDOWN_HHMM_BLINK_EN blinks the display while done=1.
module countdown_hhmm_mux
    import seg7_pkg::*;
#(
    parameter int TICK_DIV    = 5_000_000,
    parameter int SCAN_DIV    = 1024,
    parameter int HOUR_MOD    = 24,
    parameter int AUTO_RELOAD = 1
)
(
    input  logic        clk0,
    input  logic        rst_n,
    input  logic        run,
    input  logic        load,
    input  logic [15:0] preset,
    output logic [15:0] count_bcd,
    output logic [7:0]  seg7,
    output logic [3:0]  line,
    output logic        done,
    output logic        load_err
);

    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W  = $clog2(SCAN_DIV);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam bcd_digit_t         RELOAD_H10 = 4'((HOUR_MOD - 1) / 10);
    localparam bcd_digit_t         RELOAD_H1  = 4'((HOUR_MOD - 1) % 10);
    localparam logic [15:0]        RELOAD_BCD = {RELOAD_H10, RELOAD_H1, 4'd5, 4'd9};
    localparam logic [7:0]         HOUR_LIMIT = 8'(HOUR_MOD);

    // A preset is legal only as a real time of day within the hour range.
    function automatic logic bcd_valid(input logic [15:0] v);
        logic [7:0] hours;
        hours = ({4'd0, v[15:12]} * 8'd10) + {4'd0, v[11:8]};
        return (v[15:12] <= BCD_MAX) && (v[11:8] <= BCD_MAX) &&
               (v[7:4] <= 4'd5) && (v[3:0] <= BCD_MAX) && (hours < HOUR_LIMIT);
    endfunction

    // One-minute BCD decrement with borrows; caller handles the 00:00 case.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        bcd_digit_t h10, h1, m10, m1;
        h10 = v[15:12];
        h1  = v[11:8];
        m10 = v[7:4];
        m1  = v[3:0];
        if (m1 != 4'd0) begin
            m1 = m1 - 4'd1;
        end else begin
            m1 = 4'd9;
            if (m10 != 4'd0) begin
                m10 = m10 - 4'd1;
            end else begin
                m10 = 4'd5;
                if (h1 != 4'd0) begin
                    h1 = h1 - 4'd1;
                end else begin
                    h1  = 4'd9;
                    h10 = h10 - 4'd1;
                end
            end
        end
        return {h10, h1, m10, m1};
    endfunction

    logic [PRESC_W-1:0] presc_r;
    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [1:0]         slot_r;
    logic [15:0]        count_r;
    logic               done_r;
    logic               load_err_r;
    logic [3:0]         line_r;
    logic [7:0]         seg7_r;

    logic               tick_s;
    logic               scan_wrap_s;
    logic [1:0]         slot_nxt_s;
    logic [15:0]        dec_s;
    logic [15:0]        count_nxt_s;
    logic               done_nxt_s;
    logic               load_err_nxt_s;
    bcd_digit_t         digit_s;
    logic [6:0]         seg_s;
    logic               blank_s;

    assign tick_s      = (presc_r == PRESC_LAST);
    assign scan_wrap_s = &scan_cnt_r;
    assign dec_s       = bcd_dec(count_r);

    // Free-running count-step prescaler, independent of run.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PRESC_W'(1);
        end
    end

    // Next display slot: advance once per full scan-counter period.
    always_comb begin
        slot_nxt_s = slot_r;
        if (scan_wrap_s) begin
            slot_nxt_s = slot_r + 2'd1;
        end else begin
            slot_nxt_s = slot_r;
        end
    end

    // Counter next state: load beats tick; terminal 00:00 either reloads or stops.
    always_comb begin
        count_nxt_s    = count_r;
        done_nxt_s     = done_r;
        load_err_nxt_s = 1'b0;
        if (load) begin
            if (bcd_valid(preset)) begin
                count_nxt_s = preset;
                done_nxt_s  = 1'b0;
            end else begin
                load_err_nxt_s = 1'b1;
            end
        end else if (tick_s && run && !done_r) begin
            if (count_r == 16'h0000) begin
                if (AUTO_RELOAD != 0) begin
                    count_nxt_s = RELOAD_BCD;
                end else begin
                    done_nxt_s = 1'b1;
                end
            end else begin
                count_nxt_s = dec_s;
                if ((AUTO_RELOAD == 0) && (dec_s == 16'h0000)) begin
                    done_nxt_s = 1'b1;
                end else begin
                    done_nxt_s = done_r;
                end
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Digit for the slot that will be shown next cycle, taken from the next count
    // so line and seg7 always refer to the same digit of the same value.
    always_comb begin
        case (slot_nxt_s)
            2'd0:    digit_s = count_nxt_s[15:12];
            2'd1:    digit_s = count_nxt_s[11:8];
            2'd2:    digit_s = count_nxt_s[7:4];
            2'd3:    digit_s = count_nxt_s[3:0];
            default: digit_s = 4'd0;
        endcase
    end

    seg7_decode u_seg7_decode (
        .digit (digit_s),
        .seg   (seg_s)
    );

`ifdef COUNTDOWN_HHMM_BLINK_EN
    // Half-period in count steps, sized for roughly ten steps per second.
    localparam logic [2:0] BLINK_HALF_LAST = 3'd4;

    logic [2:0] blink_cnt_r;
    logic [2:0] blink_cnt_nxt_s;
    logic       blink_phase_r;
    logic       blink_phase_nxt_s;

    // Blink phase toggles every few ticks.
    always_comb begin
        blink_cnt_nxt_s   = blink_cnt_r;
        blink_phase_nxt_s = blink_phase_r;
        if (tick_s) begin
            if (blink_cnt_r == BLINK_HALF_LAST) begin
                blink_cnt_nxt_s   = 3'd0;
                blink_phase_nxt_s = ~blink_phase_r;
            end else begin
                blink_cnt_nxt_s = blink_cnt_r + 3'd1;
            end
        end else begin
            blink_cnt_nxt_s = blink_cnt_r;
        end
    end

    // Blink phase registers.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r   <= 3'd0;
            blink_phase_r <= 1'b0;
        end else begin
            blink_cnt_r   <= blink_cnt_nxt_s;
            blink_phase_r <= blink_phase_nxt_s;
        end
    end

    assign blank_s = done_nxt_s & blink_phase_nxt_s;
`else
    assign blank_s = 1'b0;
`endif

    // Counter, status and display registers.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r <= '0;
            slot_r     <= 2'd0;
            count_r    <= 16'h0000;
            done_r     <= 1'b0;
            load_err_r <= 1'b0;
            line_r     <= 4'b0001;
            seg7_r     <= 8'h3F;
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
            slot_r     <= slot_nxt_s;
            count_r    <= count_nxt_s;
            done_r     <= done_nxt_s;
            load_err_r <= load_err_nxt_s;
            line_r     <= 4'b0001 << slot_nxt_s;
            seg7_r     <= blank_s ? 8'h00 : {1'b0, seg_s};
        end
    end

    assign count_bcd = count_r;
    assign done      = done_r;
    assign load_err  = load_err_r;
    assign line      = line_r;
    assign seg7      = seg7_r;

endmodule

// File: tb/tb_countdown_hhmm_mux.sv
// Directed bench for countdown_hhmm_mux: one auto-reload instance and one
// stop-at-zero instance sharing the same stimulus.
module tb_countdown_hhmm_mux;

    logic        clk0 = 1'b0;
    logic        rst_n;
    logic        run;
    logic        load;
    logic [15:0] preset;

    logic [15:0] a_count, s_count;
    logic [7:0]  a_seg, s_seg;
    logic [3:0]  a_line, s_line;
    logic        a_done, s_done, a_err, s_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    countdown_hhmm_mux #(.TICK_DIV(4), .SCAN_DIV(4), .HOUR_MOD(24), .AUTO_RELOAD(1)) dut (
        .clk0(clk0), .rst_n(rst_n), .run(run), .load(load), .preset(preset),
        .count_bcd(a_count), .seg7(a_seg), .line(a_line), .done(a_done), .load_err(a_err)
    );

    countdown_hhmm_mux #(.TICK_DIV(4), .SCAN_DIV(4), .HOUR_MOD(24), .AUTO_RELOAD(0)) dut_stop (
        .clk0(clk0), .rst_n(rst_n), .run(run), .load(load), .preset(preset),
        .count_bcd(s_count), .seg7(s_seg), .line(s_line), .done(s_done), .load_err(s_err)
    );

    always #5 clk0 = ~clk0;

    task automatic step();
        @(posedge clk0);
        #1;
        cyc++;
    endtask

    // Advance at least one edge, stopping where cyc % 4 == m (edges with m=0 carry a tick).
    task automatic step_to(input int m);
        step();
        while ((cyc % 4) != m) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        preset = v;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_count"}, 32'(a_count), 32'h0000);
        chk({tag, "_a_done"},  32'(a_done),  32'h0);
        chk({tag, "_a_err"},   32'(a_err),   32'h0);
        chk({tag, "_a_line"},  32'(a_line),  32'h1);
        chk({tag, "_a_seg"},   32'(a_seg),   32'h3F);
        chk({tag, "_s_count"}, 32'(s_count), 32'h0000);
        chk({tag, "_s_done"},  32'(s_done),  32'h0);
        chk({tag, "_s_line"},  32'(s_line),  32'h1);
        chk({tag, "_s_seg"},   32'(s_seg),   32'h3F);
    endtask

    logic [7:0] exp_seg [4];
    logic [1:0] slot;

    initial begin
        exp_seg = '{8'h06, 8'h6F, 8'h3F, 8'h6D};
        rst_n  = 1'b0;
        run    = 1'b0;
        load   = 1'b0;
        preset = 16'h0000;
        repeat (3) @(posedge clk0);
        #1;
        chk_reset_outputs("rst");

        @(negedge clk0);
        #2;
        rst_n = 1'b1;
        cyc   = 0;

        // Wrap through 00:00 on the reload instance; stop instance latches done.
        do_load(16'h0001);
        chk("wrap_load", 32'(a_count), 32'h0001);
        run = 1'b1;
        step_to(0);
        chk("wrap_zero", 32'(a_count), 32'h0000);
        chk("wrap_zero_done", 32'(a_done), 32'h0);
        chk("stop_zero_done", 32'(s_done), 32'h1);
        step_to(0);
        chk("wrap_2359", 32'(a_count), 32'h2359);
        chk("wrap_2359_done", 32'(a_done), 32'h0);
        chk("stop_hold0", 32'(s_count), 32'h0000);

        // Stop-at-zero: 00:02 -> 00:01 -> 00:00 with done, then hold.
        do_load(16'h0002);
        chk("stop_load", 32'(s_count), 32'h0002);
        chk("stop_load_done", 32'(s_done), 32'h0);
        step_to(0);
        chk("stop_0001", 32'(s_count), 32'h0001);
        step_to(3);
        chk("stop_pre_done", 32'(s_done), 32'h0);
        step();
        chk("stop_0000", 32'(s_count), 32'h0000);
        chk("stop_done", 32'(s_done), 32'h1);
        step_to(0);
        chk("stop_hold", 32'(s_count), 32'h0000);
        chk("stop_hold_done", 32'(s_done), 32'h1);
        chk("wrap_again", 32'(a_count), 32'h2359);

        // Loading 00:00 clears done; the next tick sets it again.
        do_load(16'h0000);
        chk("zero_load_done", 32'(s_done), 32'h0);
        step_to(0);
        chk("zero_tick_done", 32'(s_done), 32'h1);
        chk("zero_tick_a", 32'(a_count), 32'h2359);

        // Rejected loads.
        run = 1'b0;
        do_load(16'h2400);
        chk("rej2400_count", 32'(a_count), 32'h2359);
        chk("rej2400_err", 32'(a_err), 32'h1);
        chk("rej2400_s_err", 32'(s_err), 32'h1);
        chk("rej2400_s_done", 32'(s_done), 32'h1);
        step();
        chk("rej_err_pulse", 32'(a_err), 32'h0);
        do_load(16'h0160);
        chk("rej0160_count", 32'(a_count), 32'h2359);
        chk("rej0160_err", 32'(a_err), 32'h1);
        step();
        chk("pause_hold", 32'(a_count), 32'h2359);
        chk("rej0160_err_clr", 32'(a_err), 32'h0);

        // Load on the tick cycle wins; the tick is discarded.
        run = 1'b1;
        step_to(3);
        preset = 16'h1234;
        load   = 1'b1;
        step();
        load   = 1'b0;
        chk("lvt_load", 32'(a_count), 32'h1234);
        chk("lvt_s_load", 32'(s_count), 32'h1234);
        chk("lvt_s_done", 32'(s_done), 32'h0);
        step_to(0);
        chk("lvt_next", 32'(a_count), 32'h1233);
        chk("lvt_s_next", 32'(s_count), 32'h1233);

        // Display scan with 19:05.
        run = 1'b0;
        do_load(16'h1905);
        chk("scan_load", 32'(a_count), 32'h1905);
        while ((cyc % 16) != 0) step();
        for (int i = 0; i < 16; i++) begin
            slot = 2'((cyc / 4) % 4);
            chk("scan_line", 32'(a_line), 32'(4'b0001 << slot));
            chk("scan_seg", 32'(a_seg), 32'(exp_seg[slot]));
            step();
        end

        // Asynchronous reset mid-count.
        run = 1'b1;
        step_to(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        @(negedge clk0);
        #2;
        rst_n = 1'b1;
        cyc   = 0;
        step_to(0);
        chk("post_rst_a", 32'(a_count), 32'h2359);
        chk("post_rst_s", 32'(s_count), 32'h0000);
        chk("post_rst_s_done", 32'(s_done), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
